// File: rtl/pcs_rx_pkg.sv
// rtl/pcs_rx_pkg.sv - K28.5 comma constants and align-state enum for the PCS receive path
package pcs_rx_pkg;

  localparam logic [9:0] COMMA_K28_5_RDN = 10'h17C;
  localparam logic [9:0] COMMA_K28_5_RDP = 10'h283;

  typedef enum logic [1:0] {
    UNLOCKED = 2'd0,
    ACQUIRE  = 2'd1,
    LOCKED   = 2'd2
  } align_state_e;

  function automatic logic is_k28_5(input logic [9:0] sym);
    return (sym == COMMA_K28_5_RDN) || (sym == COMMA_K28_5_RDP);
  endfunction

endpackage

// File: rtl/comma_window_search.sv
// rtl/comma_window_search.sv - combinational K28.5 search over the ten candidates of a 20-bit window
module comma_window_search
  import pcs_rx_pkg::*;
(
  // Candidate k is w_i[k+9:k]; the top bit of the 20-bit window is never part of a candidate.
  input  logic [18:0] w_i,
  input  logic [3:0]  offset_i,
  output logic        found_o,
  output logic [3:0]  found_k_o,
  output logic        hit_cur_o
);

  logic [9:0] match;

  always_comb begin
    match = '0;
    for (int k = 0; k < 10; k++) begin
      match[k] = is_k28_5(w_i[k +: 10]);
    end
  end

  // Descending scan so the lowest matching offset wins.
  always_comb begin
    found_o   = |match;
    found_k_o = '0;
    hit_cur_o = 1'b0;
    for (int k = 9; k >= 0; k--) begin
      if (match[k]) begin
        found_k_o = 4'(k);
      end
      if (offset_i == 4'(k)) begin
        hit_cur_o = match[k];
      end
    end
  end

endmodule

// File: rtl/comma_align_lock.sv
// rtl/comma_align_lock.sv - receive symbol aligner: comma search, acquire/lock FSM, aligned output
// Define ALIGN_REALIGN_CNT_EN to add the saturating realign_count output.
module comma_align_lock
  import pcs_rx_pkg::*;
#(
  parameter int DATA_WIDTH    = 10,
  parameter int LOCK_COMMAS   = 4,
  parameter int UNLOCK_COMMAS = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  comma_det,
  output logic                  symbol_lock,
  output logic [3:0]            align_offset
`ifdef ALIGN_REALIGN_CNT_EN
  ,
  output logic [7:0]            realign_count
`endif
);

  localparam int CNT_W = $clog2(16);
  localparam logic [CNT_W-1:0] LOCK_TH   = CNT_W'(LOCK_COMMAS);
  localparam logic [CNT_W-1:0] UNLOCK_TH = CNT_W'(UNLOCK_COMMAS);

  align_state_e          state_q, state_d;
  logic [DATA_WIDTH-1:0] prev_q;
  logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
  logic                  comma_det_q, comma_det_d;
  logic [3:0]            offset_q, offset_d;
  logic [CNT_W-1:0]      acq_cnt_q, acq_cnt_d;
  logic [CNT_W-1:0]      miss_cnt_q, miss_cnt_d;

  logic [18:0] w;
  logic        found;
  logic [3:0]  found_k;
  logic        hit_cur;
  logic        capture;
  logic [3:0]  sel;

  assign w = {data_in[8:0], prev_q};

  comma_window_search u_search (
    .w_i       (w),
    .offset_i  (offset_q),
    .found_o   (found),
    .found_k_o (found_k),
    .hit_cur_o (hit_cur)
  );

  always_comb begin
    state_d    = state_q;
    offset_d   = offset_q;
    acq_cnt_d  = acq_cnt_q;
    miss_cnt_d = miss_cnt_q;
    capture    = 1'b0;

    unique case (state_q)
      UNLOCKED: begin
        if (found) begin
          capture    = 1'b1;
          acq_cnt_d  = CNT_W'(1);
          miss_cnt_d = '0;
          state_d    = (LOCK_COMMAS == 1) ? LOCKED : ACQUIRE;
        end
      end
      ACQUIRE: begin
        // A comma at the held offset beats any other match in the same window.
        if (hit_cur) begin
          if (acq_cnt_q + CNT_W'(1) >= LOCK_TH) begin
            acq_cnt_d  = LOCK_TH;
            miss_cnt_d = '0;
            state_d    = LOCKED;
          end else begin
            acq_cnt_d = acq_cnt_q + CNT_W'(1);
          end
        end else if (found) begin
          capture   = 1'b1;
          acq_cnt_d = CNT_W'(1);
        end
      end
      LOCKED: begin
        if (hit_cur) begin
          miss_cnt_d = '0;
        end else if (found) begin
          if (miss_cnt_q + CNT_W'(1) >= UNLOCK_TH) begin
            capture    = 1'b1;
            acq_cnt_d  = CNT_W'(1);
            miss_cnt_d = '0;
            state_d    = ACQUIRE;
          end else begin
            miss_cnt_d = miss_cnt_q + CNT_W'(1);
          end
        end
      end
      default: state_d = UNLOCKED;
    endcase

    if (capture) begin
      offset_d = found_k;
    end
  end

  // A freshly captured offset steers the output in the same cycle it is found.
  always_comb begin
    sel        = capture ? found_k : offset_q;
    data_out_d = '0;
    for (int k = 0; k < 10; k++) begin
      if (sel == 4'(k)) begin
        data_out_d = w[k +: DATA_WIDTH];
      end
    end
    comma_det_d = is_k28_5(data_out_d);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= UNLOCKED;
      prev_q      <= '0;
      data_out_q  <= '0;
      comma_det_q <= 1'b0;
      offset_q    <= '0;
      acq_cnt_q   <= '0;
      miss_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      prev_q      <= data_in;
      data_out_q  <= data_out_d;
      comma_det_q <= comma_det_d;
      offset_q    <= offset_d;
      acq_cnt_q   <= acq_cnt_d;
      miss_cnt_q  <= miss_cnt_d;
    end
  end

  assign data_out     = data_out_q;
  assign comma_det    = comma_det_q;
  assign symbol_lock  = (state_q == LOCKED);
  assign align_offset = offset_q;

`ifdef ALIGN_REALIGN_CNT_EN
  logic [7:0] realign_q;
  logic       realign_evt;

  assign realign_evt = (state_q == LOCKED) && (state_d == ACQUIRE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      realign_q <= '0;
    end else if (realign_evt && (realign_q != 8'hFF)) begin
      realign_q <= realign_q + 8'd1;
    end
  end

  assign realign_count = realign_q;
`endif

endmodule

// File: tb/tb_comma_align_lock.sv
// tb/tb_comma_align_lock.sv - scoreboard bench for comma_align_lock (honours ALIGN_REALIGN_CNT_EN)
module tb_comma_align_lock;

  localparam logic [9:0] D21_5 = 10'h155;
  localparam logic [9:0] KN    = 10'h17C;
  localparam logic [9:0] KP    = 10'h283;
  localparam int LOCK_N   = 4;
  localparam int UNLOCK_N = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [9:0] data_in;
  logic [9:0] data_out;
  logic       comma_det;
  logic       symbol_lock;
  logic [3:0] align_offset;
`ifdef ALIGN_REALIGN_CNT_EN
  logic [7:0] realign_count;
`endif

  always #5 clk = ~clk;

  comma_align_lock #(
    .DATA_WIDTH    (10),
    .LOCK_COMMAS   (LOCK_N),
    .UNLOCK_COMMAS (UNLOCK_N)
  ) dut (
`ifdef ALIGN_REALIGN_CNT_EN
    .realign_count (realign_count),
`endif
    .clk          (clk),
    .rst_n        (rst_n),
    .data_in      (data_in),
    .data_out     (data_out),
    .comma_det    (comma_det),
    .symbol_lock  (symbol_lock),
    .align_offset (align_offset)
  );

  typedef struct {
    logic [9:0] dout;
    logic       cd;
    logic       lock;
    logic [3:0] off;
    int         realign;
  } exp_t;

  exp_t sb[$];
  bit   bq[$];
  int   pushed;
  int   n_cmp = 0;
  int   n_err = 0;

  int         m_state, m_acq, m_miss, m_real;
  logic [3:0] m_off;
  logic [9:0] m_prev;

  int cd_seen, rdn_seen, rdp_seen, drops, bad_fill;
  bit track_fill;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_state = 0; m_off = '0; m_acq = 0; m_miss = 0; m_real = 0; m_prev = '0;
    sb.delete();
  endtask

  task automatic put_sym(input logic [9:0] s);
    for (int i = 0; i < 10; i++) begin
      bq.push_back(s[i]);
      pushed++;
    end
  endtask

  // Insert filler bits so the next symbol lands at window offset k.
  task automatic align_to(input int k);
    int z;
    z = ((k - (pushed % 10)) + 10) % 10;
    repeat (z) begin
      bq.push_back(1'b0);
      pushed++;
    end
  endtask

  task automatic step();
    logic [19:0] w;
    logic [9:0]  c;
    logic [3:0]  fk, old_off, sel;
    bit          f, hc, cap;
    exp_t        e;
    while (bq.size() < 10) put_sym(D21_5);
    for (int i = 0; i < 10; i++) data_in[i] = bq.pop_front();
    w  = {data_in, m_prev};
    f  = 0;
    fk = '0;
    for (int k = 9; k >= 0; k--) begin
      c = w[k +: 10];
      if (c == KN || c == KP) begin
        f  = 1;
        fk = 4'(k);
      end
    end
    c       = w[m_off +: 10];
    hc      = (c == KN || c == KP);
    old_off = m_off;
    cap     = 0;
    case (m_state)
      0: if (f) begin
        cap = 1; m_off = fk; m_acq = 1; m_miss = 0;
        m_state = (LOCK_N == 1) ? 2 : 1;
      end
      1: if (hc) begin
        m_acq++;
        if (m_acq >= LOCK_N) begin m_state = 2; m_miss = 0; end
      end else if (f) begin
        cap = 1; m_off = fk; m_acq = 1;
      end
      default: if (hc) begin
        m_miss = 0;
      end else if (f) begin
        m_miss++;
        if (m_miss >= UNLOCK_N) begin
          m_state = 1; cap = 1; m_off = fk; m_acq = 1; m_miss = 0;
          if (m_real < 255) m_real++;
        end
      end
    endcase
    sel       = cap ? fk : old_off;
    e.dout    = w[sel +: 10];
    e.cd      = (e.dout == KN || e.dout == KP);
    e.lock    = (m_state == 2);
    e.off     = m_off;
    e.realign = m_real;
    m_prev    = data_in;
    sb.push_back(e);

    @(posedge clk);
    #1;
    e = sb.pop_front();
    check_eq("data_out", data_out, e.dout);
    check_eq("comma_det", comma_det, e.cd);
    check_eq("symbol_lock", symbol_lock, e.lock);
    check_eq("align_offset", align_offset, e.off);
`ifdef ALIGN_REALIGN_CNT_EN
    check_eq("realign_count", realign_count, e.realign);
`endif
    if (comma_det) begin
      cd_seen++;
      if (data_out == KN) rdn_seen++;
      if (data_out == KP) rdp_seen++;
    end else if (track_fill && data_out !== D21_5) begin
      bad_fill++;
    end
    if (!symbol_lock) drops++;
  endtask

  task automatic send_comma(input logic [9:0] s, input int nfill);
    repeat (nfill) put_sym(D21_5);
    put_sym(s);
    while (bq.size() >= 10) step();
    step();
    step();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #2;
    model_reset();
    rst_n = 1'b1;
  endtask

  task automatic clear_obs();
    cd_seen = 0; rdn_seen = 0; rdp_seen = 0; drops = 0; bad_fill = 0; track_fill = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst_n   = 1'b0;
    data_in = '0;
    pushed  = 0;
    model_reset();
    clear_obs();
    #12;
    check_eq("rst_data_out", data_out, 10'h0);
    check_eq("rst_comma_det", comma_det, 1'b0);
    check_eq("rst_lock", symbol_lock, 1'b0);
    check_eq("rst_offset", align_offset, 4'd0);
    rst_n = 1'b1;

    // Test 1: D21.5 fill, comma every 8 symbols, stream shifted by 3 bits.
    align_to(3);
    send_comma(KN, 7);
    track_fill = 1;
    for (int i = 0; i < 3; i++) send_comma(KN, 7);
    check_eq("t1_lock", symbol_lock, 1'b1);
    check_eq("t1_offset", align_offset, 4'd3);
    check_eq("t1_comma_pulses", cd_seen, 4);
    check_eq("t1_fill_bad", bad_fill, 0);

    // Test 2: alternating polarities at offset 0.
    do_reset();
    clear_obs();
    align_to(0);
    for (int i = 0; i < 4; i++) send_comma((i % 2 == 0) ? KN : KP, 3);
    check_eq("t2_lock", symbol_lock, 1'b1);
    check_eq("t2_offset", align_offset, 4'd0);
    check_eq("t2_rdn", rdn_seen, 2);
    check_eq("t2_rdp", rdp_seen, 2);

    // Test 3: recapture in ACQUIRE.
    do_reset();
    align_to(3);
    send_comma(KN, 3);
    send_comma(KN, 3);
    check_eq("t3_offset_pre", align_offset, 4'd3);
    align_to(6);
    send_comma(KN, 3);
    check_eq("t3_offset", align_offset, 4'd6);
    send_comma(KN, 3);
    send_comma(KN, 3);
    check_eq("t3_lock_early", symbol_lock, 1'b0);
    send_comma(KN, 3);
    check_eq("t3_lock", symbol_lock, 1'b1);

    // Test 4: locked at 3, stream slips by one bit.
    do_reset();
    align_to(3);
    repeat (4) send_comma(KN, 3);
    check_eq("t4_lock", symbol_lock, 1'b1);
    align_to(4);
    repeat (3) send_comma(KN, 3);
    check_eq("t4_lock_hold", symbol_lock, 1'b1);
    check_eq("t4_offset_hold", align_offset, 4'd3);
    send_comma(KN, 3);
    check_eq("t4_unlock", symbol_lock, 1'b0);
    check_eq("t4_offset_new", align_offset, 4'd4);
    repeat (3) send_comma(KP, 3);
    check_eq("t4_relock", symbol_lock, 1'b1);
`ifdef ALIGN_REALIGN_CNT_EN
    check_eq("t4_realign", realign_count, 8'd1);
`endif

    // Test 5: a single foreign comma must not disturb lock.
    do_reset();
    align_to(3);
    repeat (4) send_comma(KN, 3);
    clear_obs();
    align_to(7);
    send_comma(KN, 3);
    check_eq("t5_offset", align_offset, 4'd3);
    align_to(3);
    repeat (2) send_comma(KN, 3);
    align_to(7);
    repeat (3) send_comma(KN, 3);
    check_eq("t5_offset_end", align_offset, 4'd3);
    check_eq("t5_drops", drops, 0);
    align_to(3);
    send_comma(KN, 3);

    // Test 6: asynchronous reset between edges.
    #3;
    rst_n = 1'b0;
    #1;
    check_eq("t6_data_out", data_out, 10'h0);
    check_eq("t6_comma_det", comma_det, 1'b0);
    check_eq("t6_lock", symbol_lock, 1'b0);
    check_eq("t6_offset", align_offset, 4'd0);
    model_reset();
    #1;
    rst_n = 1'b1;
    align_to(5);
    repeat (3) send_comma(KN, 3);
    check_eq("t6_not_yet", symbol_lock, 1'b0);
    send_comma(KN, 3);
    check_eq("t6_relock", symbol_lock, 1'b1);
    check_eq("t6_offset_relock", align_offset, 4'd5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/comma_align_lock.md
Name: comma_align_lock

Overview:
Receive-side PCS symbol aligner. Sits between the deserializer and the elastic buffer, and runs in the recovered-clock domain that feeds the elastic buffer's write side. It searches the unaligned 10-bit stream for K28.5 commas and locks onto a bit offset using an acquire/lock state machine. It then delivers 10-bit aligned symbols, a comma strobe and a lock indication to the elastic buffer's write side.

Parameters:
DATA_WIDTH, 10, symbol width; the block supports only 10.
LOCK_COMMAS, 4, consecutive commas at one offset needed to enter LOCKED (range 1..15).
UNLOCK_COMMAS, 4, consecutive commas at a foreign offset that force an exit from LOCKED (range 1..15).

Ports:
clk  input  1  recovered symbol clock; single clock domain.
rst_n  input  1  asynchronous, active-low reset.
data_in  input  10  raw deserializer word; data_in[0] is the first bit received (bit a).
data_out  output  10  aligned symbol, registered.
comma_det  output  1  1 when the current data_out is K28.5 (either running disparity).
symbol_lock  output  1  1 while the FSM is in LOCKED.
align_offset  output  4  current bit offset, 0..9.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - state=UNLOCKED; prev_word, data_out, comma_det, symbol_lock, align_offset, acq_cnt and miss_cnt all 0.
- Window:
  - prev_word is registered each clk from data_in.
  - w[19:0] = {data_in, prev_word}; candidate k is w[k+9:k], for k=0..9.
- Comma match:
  - A candidate matches if it equals 10'h17C (RD-) or 10'h283 (RD+).
  - found = any match; found_k = lowest matching k.
  - hit_cur = the candidate at the held offset matches.
- Offset select:
  - sel = found_k when the FSM captures a new offset this cycle; otherwise sel = held offset.
- Outputs, registered:
  - data_out <= w[sel+9:sel].
  - comma_det <= match at sel.
  - A comma whose last bit arrives in cycle t appears on data_out at t+1, so latency is 1 clk from window completion.
- FSM:
  - UNLOCKED: if found, capture offset=found_k, acq_cnt=1 and go to ACQUIRE. If LOCK_COMMAS=1, go directly to LOCKED.
  - ACQUIRE:
    - hit_cur: acq_cnt+1; when the count reaches LOCK_COMMAS, go to LOCKED with miss_cnt=0.
    - found && !hit_cur: recapture offset=found_k and set acq_cnt=1.
    - Non-comma words: no change.
  - LOCKED:
    - hit_cur: miss_cnt=0.
    - found && !hit_cur: miss_cnt+1; on reaching UNLOCK_COMMAS, go to ACQUIRE with offset=found_k and acq_cnt=1, and symbol_lock falls on the same edge.
    - Non-comma words leave miss_cnt unchanged.
- Priority: hit_cur takes precedence over any other matching offset in the same window.
- Counters are sized $clog2(16) and never exceed their thresholds.
- symbol_lock and align_offset are registered and reflect the state and offset after the edge.

Optional Feature:
ALIGN_REALIGN_CNT_EN
- Defined: adds output port realign_count [7:0]. It increments on every LOCKED->ACQUIRE transition, saturates at 255, and resets to 0.
- Undefined: the port and counter are absent; all other behaviour is identical.

Decomposition:
- Package pcs_rx_pkg holds:
  - constants COMMA_K28_5_RDN=10'h17C and COMMA_K28_5_RDP=10'h283;
  - the align-state enum {UNLOCKED, ACQUIRE, LOCKED}.
- One combinational sub-module, comma_window_search: takes w[19:0] and offset, and returns found, found_k and hit_cur. The top level holds the registers, FSM and output mux.

Test Plan:
1. Test 1: D21.5 fill with K28.5 RD- every 8 symbols, stream shifted 3 bits, 4 commas.
   - symbol_lock=1 after the 4th comma's output edge; align_offset=3; data_out reproduces the original symbols; comma_det pulses once per comma.
2. Test 2: alternating RD-/RD+ commas at offset 0.
   - Both polarities are detected; lock after 4; data_out=17C/283 on comma_det cycles.
3. Test 3: in ACQUIRE at offset 3 with acq_cnt=2, a comma arrives at offset 6.
   - align_offset=6, acq_cnt=1; lock requires 3 more commas at 6.
4. Test 4: locked at 3, stream slips to offset 4 for 4 commas.
   - symbol_lock drops on the 4th; state ACQUIRE at offset 4; relock after 3 more commas. With ALIGN_REALIGN_CNT_EN, realign_count=1.
5. Test 5: locked; one comma at offset 7, then commas at 3.
   - miss_cnt returns to 0; symbol_lock stays 1 throughout.
6. Test 6: assert rst_n=0 mid-lock, between clk edges.
   - All outputs read 0 immediately, without waiting for an edge; after release, lock is reacquired from UNLOCKED.
